dm_abstract_cmd: RTL and testbench
==================================

# dm_abstract_cmd

Abstract-command front end of the debug module. It captures DMI writes to `command`, `abstractcs` and `abstractauto`, and decides whether each trigger is accepted. It issues a one-cycle `cmd_valid_o` with a supported/unsupported flag to `dm_core_control`, then tracks completion. It also owns the sticky `cmderror` field, busy-write detection, autoexec re-triggering and `aarpostincrement` of `regno`.

## Interface
Parameters:
- NrData, 2, number of data registers (autoexecdata width used)
- NrProgBuf, 8, number of progbuf words (autoexecprogbuf width used)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- dmactive_i  in  1  0 → synchronous clear of all state to reset values
- command_we_i  in  1  DMI write strobe, `command` (0x17)
- abstractcs_we_i  in  1  DMI write strobe, `abstractcs` (0x16)
- abstractauto_we_i  in  1  DMI write strobe, `abstractauto` (0x18)
- dmi_wdata_i  in  32  DMI write data
- data_access_i  in  NrData  one-hot pulse, DMI read or write of data[i]
- progbuf_access_i  in  NrProgBuf  one-hot pulse, DMI read or write of progbuf[i]
- cmdbusy_i  in  1  from core control
- cmderror_valid_i  in  1  from core control
- cmderror_i  in  3  from core control
- cmd_valid_o  out  1  one-cycle issue pulse
- unsupported_command_o  out  1  latched command unsupported; qualified by cmd_valid_o
- command_o  out  32  latched command (regno updated by postincrement)
- busy_o  out  1  `abstractcs.busy`
- cmderror_o  out  3  sticky `abstractcs.cmderror`
- abstractauto_o  out  32  {autoexecprogbuf[31:16], 4'b0, autoexecdata[11:0]}, unused bits 0

## Operation
- States:
  - IDLE: no command in flight.
  - ISSUE: one cycle; `cmd_valid_o` = 1.
  - WAIT: wait for core control to finish.
- Trigger sources (IDLE only):
  - `command_we_i`: latches `dmi_wdata_i` into `command_o`.
  - `data_access_i[i]` with autoexecdata[i] = 1.
  - `progbuf_access_i[j]` with autoexecprogbuf[j] = 1.
  - Autoexec triggers reuse the latched command.
- Acceptance:
  - Accepted only if `busy_o` = 0 and `cmderror_o` = 0. Accepted → ISSUE.
  - A `command_we_i` while `cmderror_o` ≠ 0 and not busy: ignored, `command_o` unchanged.
  - Any trigger-class access (command/abstractauto write, autoexec-enabled data/progbuf access) while `busy_o` = 1: if `cmderror_o` = 0, set it to 1 (Busy). The write is discarded.
- Support decode (combinational, on latched command):
  - Supported only when all hold: cmdtype = 0; aarsize = 2 when transfer = 1; regno in 0x0000–0x0FFF (CSR) or 0x1000–0x101F (GPR) when transfer = 1.
  - All other commands, including cmdtype 1/2, are unsupported.
- ISSUE → IDLE in two cases:
  - unsupported; core control reports NotSupported the same cycle;
  - `cmderror_valid_i` = 1 in that cycle (HaltResume).
  Otherwise ISSUE → WAIT.
- WAIT → IDLE when `cmdbusy_i` = 0.
  - On that exit, if aarpostincrement = 1 and no error was captured during the command: regno ← regno + 1, 16-bit wrap (0xFFFF → 0x0000).
- `busy_o` = (state ≠ IDLE) | `cmdbusy_i`.
- cmderror:
  - Capture `cmderror_i` when `cmderror_valid_i` = 1 and `cmderror_o` = 0. The first error wins; later errors are ignored.
  - `abstractcs_we_i` clears the bits where `dmi_wdata_i[10:8]` = 1 (W1C).
  - A new error capture in the same cycle as a W1C overrides the clear.
- `abstractauto_we_i` when not busy: latches autoexecdata = `wdata[NrData-1:0]` and autoexecprogbuf = `wdata[16+NrProgBuf-1:16]`.
- Simultaneous `command_we_i` and an autoexec access: one trigger. The new command is latched and used.
- `dmactive_i` = 0 or reset mid-command: state → IDLE, no further `cmd_valid_o`.

## Timing
- Reset values: state IDLE; `cmd_valid_o`, `unsupported_command_o`, `busy_o` 0; `command_o` 0; `cmderror_o` 0; `abstractauto_o` 0.
- Latency: trigger in cycle N → `cmd_valid_o` = 1 in cycle N+1. `busy_o` = 1 from cycle N+1.
- `cmd_valid_o` is never asserted for two consecutive cycles. After a completion, the next issue comes at least 1 IDLE cycle later.
- Core control response (error or Go) is sampled in the ISSUE cycle. `cmdbusy_i` is expected high from cycle N+2 until done.
- A postincremented regno is visible on `command_o` the cycle after WAIT exits.

## Structure
- `dm_pkg` holds: cmderror codes (None 0, Busy 1, NotSupported 2, Exception 3, HaltResume 4, Bus 5, Other 7); cmdtype codes; command field positions (regno[15:0], write 16, transfer 17, postexec 18, postincrement 19, aarsize[22:20], cmdtype[31:24]); state encoding; DMI addresses 0x16–0x18. Core control uses the same package.
- One sub-module, `dm_cmd_decode`: the combinational support check, reused by both the issue and postincrement paths.

## Test plan
- Command write 0x0022_1008 (GPR x8, transfer, aarsize 2), core halted → `cmd_valid_o` pulse at N+1, `unsupported_command_o` 0, `busy_o` high until `cmdbusy_i` falls, `cmderror_o` 0.
- Command write 0x0032_1008 (aarsize 3) → `unsupported_command_o` = 1 with the pulse, `cmderror_o` = 2, state back to IDLE next cycle.
- Command write while `cmdbusy_i` = 1 → `cmderror_o` = 1, `command_o` unchanged. Then a command write with cmderror 1 is ignored. Write `abstractcs` 0x700 → `cmderror_o` = 0.
- autoexecdata = 1, postincrement command regno 0x1005, three data0 accesses, each after completion → three issues, regno 0x1006/0x1007/0x1008.
- Core control reports HaltResume in ISSUE → `cmderror_o` = 4, no WAIT, regno not incremented. Deassert `dmactive_i` in WAIT → all outputs reset next cycle.

Source files
------------

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared debug-module types, codes and command field layout
//
// Purpose: definitions used by the abstract-command front end and by core
// control: cmderror codes, cmdtype codes, command field positions, the
// front-end state encoding and the DMI register addresses it decodes.
// Ports: none (package).

package dm_pkg;

  typedef enum logic [2:0] {
    CmdErrNone         = 3'd0,
    CmdErrBusy         = 3'd1,
    CmdErrNotSupported = 3'd2,
    CmdErrException    = 3'd3,
    CmdErrHaltResume   = 3'd4,
    CmdErrBus          = 3'd5,
    CmdErrOther        = 3'd7
  } cmderr_e;

  typedef enum logic [7:0] {
    AccessRegister = 8'h00,
    QuickAccess    = 8'h01,
    AccessMemory   = 8'h02
  } cmdtype_e;

  // Access-register command layout
  localparam int unsigned CmdRegnoLsb    = 0;
  localparam int unsigned CmdRegnoW      = 16;
  localparam int unsigned CmdWriteBit    = 16;
  localparam int unsigned CmdTransferBit = 17;
  localparam int unsigned CmdPostexecBit = 18;
  localparam int unsigned CmdPostincBit  = 19;
  localparam int unsigned CmdAarsizeLsb  = 20;
  localparam int unsigned CmdAarsizeW    = 3;
  localparam int unsigned CmdTypeLsb     = 24;
  localparam int unsigned CmdTypeW       = 8;

  localparam logic [2:0]  Aarsize32    = 3'd2;
  // CSRs 0x0000-0x0FFF and GPRs 0x1000-0x101F form one contiguous range
  localparam logic [15:0] RegnoGprLast = 16'h101F;

  typedef enum logic [1:0] {
    CmdIdle  = 2'd0,
    CmdIssue = 2'd1,
    CmdWait  = 2'd2
  } cmd_state_e;

  localparam logic [6:0] DmiAbstractcs   = 7'h16;
  localparam logic [6:0] DmiCommand      = 7'h17;
  localparam logic [6:0] DmiAbstractauto = 7'h18;

endpackage

// File: rtl/dm_cmd_decode.sv
// rtl/dm_cmd_decode.sv - combinational support check of the latched abstract command
//
// Purpose: decides whether the latched command can be executed and provides
// the postincrement flag and the wrapped regno+1 used on completion.
// Ports:
//   command_i        latched 32-bit abstract command
//   supported_o      1 when the command is an executable access-register command
//   postincrement_o  aarpostincrement bit
//   regno_inc_o      regno + 1, 16-bit wrap

module dm_cmd_decode
  import dm_pkg::*;
(
  input  logic [31:0] command_i,
  output logic        supported_o,
  output logic        postincrement_o,
  output logic [15:0] regno_inc_o
);

  logic [CmdTypeW-1:0]    cmdtype;
  logic [CmdAarsizeW-1:0] aarsize;
  logic                   transfer;
  logic [CmdRegnoW-1:0]   regno;
  logic                   unused_cmd_bits;

  assign cmdtype  = command_i[CmdTypeLsb +: CmdTypeW];
  assign aarsize  = command_i[CmdAarsizeLsb +: CmdAarsizeW];
  assign transfer = command_i[CmdTransferBit];
  assign regno    = command_i[CmdRegnoLsb +: CmdRegnoW];

  // write/postexec and the reserved bit do not affect support
  assign unused_cmd_bits = ^{command_i[CmdWriteBit], command_i[CmdPostexecBit], command_i[23]};

  // Without transfer, size and regno are irrelevant
  assign supported_o = (cmdtype == AccessRegister) &&
                       (!transfer || ((aarsize == Aarsize32) && (regno <= RegnoGprLast)));

  assign postincrement_o = command_i[CmdPostincBit];
  assign regno_inc_o     = regno + 16'd1;

endmodule

// File: rtl/dm_abstract_cmd.sv
// rtl/dm_abstract_cmd.sv - abstract-command front end of the debug module
//
// Purpose: captures DMI writes to command/abstractcs/abstractauto, accepts or
// rejects command triggers, issues a one-cycle request to core control, tracks
// completion, owns the sticky cmderror field, autoexec and regno postincrement.
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   dmactive_i                       0 clears all state synchronously
//   command_we_i / abstractcs_we_i / abstractauto_we_i   DMI write strobes
//   dmi_wdata_i                      DMI write data
//   data_access_i / progbuf_access_i one-hot DMI access pulses (autoexec)
//   cmdbusy_i, cmderror_valid_i, cmderror_i   status from core control
//   cmd_valid_o, unsupported_command_o        issue pulse and its qualifier
//   command_o                        latched command
//   busy_o, cmderror_o               abstractcs.busy / abstractcs.cmderror
//   abstractauto_o                   abstractauto register readback

module dm_abstract_cmd
  import dm_pkg::*;
#(
  parameter int unsigned NrData    = 2,
  parameter int unsigned NrProgBuf = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 dmactive_i,
  input  logic                 command_we_i,
  input  logic                 abstractcs_we_i,
  input  logic                 abstractauto_we_i,
  input  logic [31:0]          dmi_wdata_i,
  input  logic [NrData-1:0]    data_access_i,
  input  logic [NrProgBuf-1:0] progbuf_access_i,
  input  logic                 cmdbusy_i,
  input  logic                 cmderror_valid_i,
  input  logic [2:0]           cmderror_i,
  output logic                 cmd_valid_o,
  output logic                 unsupported_command_o,
  output logic [31:0]          command_o,
  output logic                 busy_o,
  output logic [2:0]           cmderror_o,
  output logic [31:0]          abstractauto_o
);

  cmd_state_e           state_q, state_d;
  logic [31:0]          command_q, command_d;
  logic [2:0]           cmderror_q, cmderror_d;
  logic [NrData-1:0]    autodata_q, autodata_d;
  logic [NrProgBuf-1:0] autopb_q, autopb_d;
  logic                 err_seen_q, err_seen_d;

  logic        supported;
  logic        postincrement;
  logic [15:0] regno_inc;
  logic        busy;
  logic        auto_hit;
  logic        trig_access;
  logic        busy_err;
  logic        issue_req;
  logic        capture;

  dm_cmd_decode u_decode (
    .command_i       (command_q),
    .supported_o     (supported),
    .postincrement_o (postincrement),
    .regno_inc_o     (regno_inc)
  );

  assign busy        = (state_q != CmdIdle) | cmdbusy_i;
  assign auto_hit    = (|(data_access_i & autodata_q)) | (|(progbuf_access_i & autopb_q));
  // Every access that could start or alter a command counts against a busy engine
  assign trig_access = command_we_i | abstractauto_we_i | auto_hit;
  assign busy_err    = busy & trig_access & (cmderror_q == CmdErrNone);
  assign issue_req   = ~busy & (cmderror_q == CmdErrNone) & (command_we_i | auto_hit);
  assign capture     = cmderror_valid_i & (cmderror_q == CmdErrNone);

  always_comb begin
    state_d    = state_q;
    command_d  = command_q;
    cmderror_d = cmderror_q;
    autodata_d = autodata_q;
    autopb_d   = autopb_q;
    err_seen_d = err_seen_q;

    // Priority: captured error over busy error over W1C clear
    if (abstractcs_we_i) cmderror_d = cmderror_q & ~dmi_wdata_i[10:8];
    if (busy_err)        cmderror_d = CmdErrBusy;
    if (capture)         cmderror_d = cmderror_i;

    if (abstractauto_we_i && !busy) begin
      autodata_d = dmi_wdata_i[NrData-1:0];
      autopb_d   = dmi_wdata_i[16 +: NrProgBuf];
    end

    // Any error reported while a command runs suppresses its postincrement,
    // even if cmderror already held an earlier value
    if ((state_q != CmdIdle) && cmderror_valid_i) err_seen_d = 1'b1;

    unique case (state_q)
      CmdIdle: begin
        if (issue_req) begin
          // A concurrent autoexec access merges into this single trigger
          if (command_we_i) command_d = dmi_wdata_i;
          err_seen_d = 1'b0;
          state_d    = CmdIssue;
        end
      end
      CmdIssue: begin
        // Unsupported commands are reported by core control in this cycle
        if (!supported || cmderror_valid_i) state_d = CmdIdle;
        else                                state_d = CmdWait;
      end
      CmdWait: begin
        if (!cmdbusy_i) begin
          state_d = CmdIdle;
          if (postincrement && !err_seen_q && !cmderror_valid_i) begin
            command_d[CmdRegnoLsb +: CmdRegnoW] = regno_inc;
          end
        end
      end
      default: state_d = CmdIdle;
    endcase

    if (!dmactive_i) begin
      state_d    = CmdIdle;
      command_d  = '0;
      cmderror_d = '0;
      autodata_d = '0;
      autopb_d   = '0;
      err_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= CmdIdle;
      command_q  <= '0;
      cmderror_q <= '0;
      autodata_q <= '0;
      autopb_q   <= '0;
      err_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      command_q  <= command_d;
      cmderror_q <= cmderror_d;
      autodata_q <= autodata_d;
      autopb_q   <= autopb_d;
      err_seen_q <= err_seen_d;
    end
  end

  assign cmd_valid_o           = (state_q == CmdIssue);
  assign unsupported_command_o = cmd_valid_o & ~supported;
  assign command_o             = command_q;
  assign busy_o                = busy;
  assign cmderror_o            = cmderror_q;

  always_comb begin
    abstractauto_o                   = '0;
    abstractauto_o[NrData-1:0]       = autodata_q;
    abstractauto_o[16 +: NrProgBuf]  = autopb_q;
  end

endmodule

// File: tb/tb_dm_abstract_cmd.sv
// tb/tb_dm_abstract_cmd.sv - self-checking bench for dm_abstract_cmd

module tb_dm_abstract_cmd;

  localparam int NrData    = 2;
  localparam int NrProgBuf = 8;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 dmactive_i;
  logic                 command_we_i;
  logic                 abstractcs_we_i;
  logic                 abstractauto_we_i;
  logic [31:0]          dmi_wdata_i;
  logic [NrData-1:0]    data_access_i;
  logic [NrProgBuf-1:0] progbuf_access_i;
  logic                 cmdbusy_i;
  logic                 cmderror_valid_i;
  logic [2:0]           cmderror_i;
  logic                 cmd_valid_o;
  logic                 unsupported_command_o;
  logic [31:0]          command_o;
  logic                 busy_o;
  logic [2:0]           cmderror_o;
  logic [31:0]          abstractauto_o;

  int checks   = 0;
  int failures = 0;

  // Reference state: what the debugger would read back
  logic [31:0]          m_cmd;
  logic [2:0]           m_err;
  logic [NrData-1:0]    m_ad;
  logic [NrProgBuf-1:0] m_apb;

  dm_abstract_cmd #(.NrData(NrData), .NrProgBuf(NrProgBuf)) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .dmactive_i            (dmactive_i),
    .command_we_i          (command_we_i),
    .abstractcs_we_i       (abstractcs_we_i),
    .abstractauto_we_i     (abstractauto_we_i),
    .dmi_wdata_i           (dmi_wdata_i),
    .data_access_i         (data_access_i),
    .progbuf_access_i      (progbuf_access_i),
    .cmdbusy_i             (cmdbusy_i),
    .cmderror_valid_i      (cmderror_valid_i),
    .cmderror_i            (cmderror_i),
    .cmd_valid_o           (cmd_valid_o),
    .unsupported_command_o (unsupported_command_o),
    .command_o             (command_o),
    .busy_o                (busy_o),
    .cmderror_o            (cmderror_o),
    .abstractauto_o        (abstractauto_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_strobes();
    command_we_i      = 1'b0;
    abstractcs_we_i   = 1'b0;
    abstractauto_we_i = 1'b0;
    data_access_i     = '0;
    progbuf_access_i  = '0;
    cmderror_valid_i  = 1'b0;
    cmderror_i        = 3'd0;
  endtask

  function automatic bit exp_supported(input logic [31:0] c);
    logic [7:0]  ctype;
    logic [2:0]  size;
    logic [15:0] regno;
    ctype = c[31:24];
    size  = c[22:20];
    regno = c[15:0];
    if (ctype != 8'd0) return 1'b0;
    if (!c[17]) return 1'b1;
    return (size == 3'd2) && (regno < 16'h1020);
  endfunction

  function automatic logic [31:0] exp_auto();
    return (32'(m_apb) << 16) | 32'(m_ad);
  endfunction

  // First error wins
  task automatic set_err(input logic [2:0] code);
    if (m_err == 3'd0) m_err = code;
  endtask

  function automatic logic [31:0] rand_cmd();
    logic [31:0] c;
    logic [15:0] picks [4];
    picks = '{16'hFFFF, 16'h101F, 16'h1020, 16'h0FFF};
    c = '0;
    c[31:24] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 2)) : 8'h00;
    c[22:20] = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
    c[19]    = 1'($urandom_range(0, 1));
    c[18]    = 1'($urandom_range(0, 1));
    c[17]    = ($urandom_range(0, 3) != 0);
    c[16]    = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       c[15:0] = 16'($urandom_range(0, 'h0FFF));
      1:       c[15:0] = 16'($urandom_range('h1000, 'h101F));
      2:       c[15:0] = 16'($urandom_range('h1020, 'hFFFF));
      default: c[15:0] = picks[$urandom_range(0, 3)];
    endcase
    return c;
  endfunction

  task automatic wr_abstractcs(input logic [2:0] mask);
    clr_strobes();
    abstractcs_we_i = 1'b1;
    dmi_wdata_i     = 32'(mask) << 8;
    tick();
    clr_strobes();
    m_err = m_err & ~mask;
    #1;
    chk("w1c_err", 32'(cmderror_o), 32'(m_err));
  endtask

  task automatic wr_auto(input logic [31:0] wdata);
    clr_strobes();
    abstractauto_we_i = 1'b1;
    dmi_wdata_i       = wdata;
    tick();
    clr_strobes();
    m_ad  = wdata[NrData-1:0];
    m_apb = wdata[16 +: NrProgBuf];
    #1;
    chk("auto_wr", abstractauto_o, exp_auto());
  endtask

  // Trigger-class or benign DMI access while the engine is busy
  task automatic do_poke(input int kind);
    int i;
    case (kind)
      0: begin
        command_we_i = 1'b1;
        dmi_wdata_i  = $urandom;
        set_err(3'd1);
      end
      1: begin
        abstractauto_we_i = 1'b1;
        dmi_wdata_i       = $urandom;
        set_err(3'd1);
      end
      default: begin
        i = $urandom_range(0, NrData - 1);
        data_access_i[i] = 1'b1;
        if (m_ad[i]) set_err(3'd1);
      end
    endcase
  endtask

  // resp: 0 go, 1 HaltResume in ISSUE, 2 Exception during WAIT
  // poke_kind: -1 none, 0..2 forced on first WAIT cycle, 4 random when no postincrement
  task automatic do_trigger(input bit use_cmd, input logic [31:0] wdata, input int didx,
                            input int pidx, input int resp, input int wlen,
                            input int poke_kind, input bit w1c_in_issue);
    bit trig, acc, sup, exc;
    int pk;
    clr_strobes();
    if (use_cmd) begin
      command_we_i = 1'b1;
      dmi_wdata_i  = wdata;
    end
    if (didx >= 0) data_access_i[didx] = 1'b1;
    if (pidx >= 0) progbuf_access_i[pidx] = 1'b1;
    #1;
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_valid", 32'(cmd_valid_o), 32'd0);
    trig = use_cmd || ((didx >= 0) && m_ad[didx]) || ((pidx >= 0) && m_apb[pidx]);
    acc  = trig && (m_err == 3'd0);
    if (acc && use_cmd) m_cmd = wdata;
    tick();
    clr_strobes();
    if (!acc) begin
      #1;
      chk("noissue_valid", 32'(cmd_valid_o), 32'd0);
      chk("noissue_busy", 32'(busy_o), 32'd0);
      chk("noissue_cmd", command_o, m_cmd);
      return;
    end
    sup = exp_supported(m_cmd);
    if (!sup) begin
      cmderror_valid_i = 1'b1;
      cmderror_i       = 3'd2;
    end else if (resp == 1) begin
      cmderror_valid_i = 1'b1;
      cmderror_i       = 3'd4;
    end
    if (w1c_in_issue) begin
      abstractcs_we_i = 1'b1;
      dmi_wdata_i     = 32'h0000_0700;
    end
    #1;
    chk("issue_valid", 32'(cmd_valid_o), 32'd1);
    chk("issue_unsup", 32'(unsupported_command_o), 32'(!sup));
    chk("issue_busy", 32'(busy_o), 32'd1);
    chk("issue_cmd", command_o, m_cmd);
    if (w1c_in_issue) m_err = 3'd0;
    if (!sup) set_err(3'd2);
    else if (resp == 1) set_err(3'd4);
    if (!sup || resp == 1) begin
      tick();
      clr_strobes();
      #1;
      chk("abort_valid", 32'(cmd_valid_o), 32'd0);
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("abort_err", 32'(cmderror_o), 32'(m_err));
      chk("abort_cmd", command_o, m_cmd);
      return;
    end
    pk = poke_kind;
    if (poke_kind == 4) pk = (!m_cmd[19] && $urandom_range(0, 1) == 1) ? $urandom_range(0, 2) : -1;
    tick();
    clr_strobes();
    cmdbusy_i = 1'b1;
    exc = 1'b0;
    for (int k = 0; k < wlen; k++) begin
      if (resp == 2 && k == wlen - 1) begin
        cmderror_valid_i = 1'b1;
        cmderror_i       = 3'd3;
        set_err(3'd3);
        exc = 1'b1;
      end
      if (pk >= 0 && k == 0) do_poke(pk);
      #1;
      chk("wait_valid", 32'(cmd_valid_o), 32'd0);
      chk("wait_busy", 32'(busy_o), 32'd1);
      tick();
      clr_strobes();
    end
    cmdbusy_i = 1'b0;
    #1;
    chk("exit_busy", 32'(busy_o), 32'd1);
    chk("exit_valid", 32'(cmd_valid_o), 32'd0);
    tick();
    if (m_cmd[19] && !exc) m_cmd[15:0] = m_cmd[15:0] + 16'd1;
    #1;
    chk("done_busy", 32'(busy_o), 32'd0);
    chk("done_valid", 32'(cmd_valid_o), 32'd0);
    chk("done_cmd", command_o, m_cmd);
    chk("done_err", 32'(cmderror_o), 32'(m_err));
    chk("done_auto", abstractauto_o, exp_auto());
  endtask

  initial begin
    bit use_cmd;
    int didx, pidx, r, resp;

    rst_ni     = 1'b0;
    dmactive_i = 1'b1;
    cmdbusy_i  = 1'b0;
    dmi_wdata_i = '0;
    clr_strobes();
    m_cmd = '0;
    m_err = '0;
    m_ad  = '0;
    m_apb = '0;

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", 32'(cmd_valid_o), 32'd0);
    chk("rst_unsup", 32'(unsupported_command_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_cmd", command_o, 32'd0);
    chk("rst_err", 32'(cmderror_o), 32'd0);
    chk("rst_auto", abstractauto_o, 32'd0);
    rst_ni = 1'b1;
    tick();

    do_trigger(1'b1, 32'h0022_1008, -1, -1, 0, 3, -1, 1'b0);
    do_trigger(1'b1, 32'h0032_1008, -1, -1, 0, 1, -1, 1'b0);
    wr_abstractcs(3'b111);
    do_trigger(1'b1, 32'h0022_1008, -1, -1, 0, 3, 0, 1'b0);
    do_trigger(1'b1, 32'h0022_1010, -1, -1, 0, 2, -1, 1'b0);
    wr_abstractcs(3'b111);
    do_trigger(1'b1, 32'h0022_1008, -1, -1, 0, 2, 1, 1'b0);
    wr_abstractcs(3'b111);
    wr_auto(32'h0000_0001);
    do_trigger(1'b1, 32'h002A_1005, -1, -1, 0, 2, -1, 1'b0);
    repeat (3) do_trigger(1'b0, 32'h0, 0, -1, 0, 2, -1, 1'b0);
    do_trigger(1'b0, 32'h0, 0, -1, 1, 2, -1, 1'b1);
    wr_abstractcs(3'b100);
    wr_auto(32'h0080_0002);
    do_trigger(1'b1, 32'h0008_FFFF, 1, 7, 0, 1, -1, 1'b0);
    do_trigger(1'b0, 32'h0, 0, -1, 0, 1, -1, 1'b0);
    do_trigger(1'b0, 32'h0, -1, 7, 2, 2, -1, 1'b0);
    wr_abstractcs(3'b111);
    do_trigger(1'b1, 32'h0022_101F, -1, -1, 0, 1, -1, 1'b0);
    do_trigger(1'b1, 32'h0022_1020, -1, -1, 0, 1, -1, 1'b0);
    wr_abstractcs(3'b111);
    do_trigger(1'b1, 32'h0100_0000, -1, -1, 0, 1, -1, 1'b0);
    wr_abstractcs(3'b111);

    for (int it = 0; it < 80; it++) begin
      if (m_err != 3'd0 || $urandom_range(0, 3) == 0) wr_abstractcs(3'($urandom_range(0, 7)));
      if ($urandom_range(0, 4) == 0) wr_auto($urandom);
      use_cmd = ($urandom_range(0, 1) == 1);
      didx    = $urandom_range(0, 2) - 1;
      pidx    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NrProgBuf - 1) : -1;
      r       = $urandom_range(0, 4);
      resp    = (r <= 2) ? 0 : r - 2;
      do_trigger(use_cmd, rand_cmd(), didx, pidx, resp, $urandom_range(1, 4), 4, 1'b0);
    end

    // dmactive drop in WAIT clears everything
    wr_abstractcs(3'b111);
    wr_auto(32'h00FF_0003);
    clr_strobes();
    command_we_i = 1'b1;
    dmi_wdata_i  = 32'h0022_1008;
    tick();
    clr_strobes();
    #1;
    chk("dma_issue", 32'(cmd_valid_o), 32'd1);
    tick();
    cmdbusy_i = 1'b1;
    #1;
    chk("dma_wait_busy", 32'(busy_o), 32'd1);
    dmactive_i = 1'b0;
    tick();
    dmactive_i = 1'b1;
    cmdbusy_i  = 1'b0;
    #1;
    chk("dma_valid", 32'(cmd_valid_o), 32'd0);
    chk("dma_busy", 32'(busy_o), 32'd0);
    chk("dma_cmd", command_o, 32'd0);
    chk("dma_err", 32'(cmderror_o), 32'd0);
    chk("dma_auto", abstractauto_o, 32'd0);
    tick();
    chk("dma_valid2", 32'(cmd_valid_o), 32'd0);

    // Asynchronous reset in the ISSUE cycle
    clr_strobes();
    command_we_i = 1'b1;
    dmi_wdata_i  = 32'h0022_1008;
    tick();
    clr_strobes();
    #1;
    chk("arst_issue", 32'(cmd_valid_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(cmd_valid_o), 32'd0);
    chk("arst_cmd", command_o, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_valid2", 32'(cmd_valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
